// File: rtl/mul_arb_seq.sv
// mul_arb_seq: two-requester round-robin front end sharing one iterative 8x8 shift-add multiplier.
// Define MUL_SKIP_ZERO_EN to end the run once no set multiplier bits remain above the current bit.
module mul_arb_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic        req1,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [15:0] p
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] a, b;
    logic [15:0] acc, sum;
    logic [2:0] cnt;
    logic last, win, id, last_step;
    always_comb begin
        win = (req0 && req1) ? !last : req1;
        sum = acc + (b[cnt] ? ({8'b0, a} << cnt) : 16'd0);
`ifdef MUL_SKIP_ZERO_EN
        last_step = (b >> cnt) <= 8'd1;
`else
        last_step = cnt == 3'd7;
`endif
        state_nx = state;
        case (state)
            IDLE:    state_nx = (req0 || req1) ? RUN : IDLE;
            RUN:     state_nx = last_step ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            p       <= 16'd0;
            acc     <= 16'd0;
            cnt     <= 3'd0;
            last    <= 1'b1;
            id      <= 1'b0;
            a       <= 8'd0;
            b       <= 8'd0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            if (state == IDLE && (req0 || req1)) begin
                gnt0 <= !win;
                gnt1 <= win;
                id   <= win;
                last <= win;
                a    <= win ? a1 : a0;
                b    <= win ? b1 : b0;
                acc  <= 16'd0;
                cnt  <= 3'd0;
                busy <= 1'b1;
            end else if (state == RUN) begin
                acc <= sum;
                cnt <= cnt + 3'd1;
                if (last_step) begin
                    done    <= 1'b1;
                    p       <= sum;
                    done_id <= id;
                end
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mul_arb_seq.sv
// tb_mul_arb_seq: directed and randomized checks of mul_arb_seq against a transaction-level model.
module tb_mul_arb_seq;
    logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
    logic gnt0, gnt1, busy, done, done_id;
    logic [15:0] p;
    int tests = 0, fails = 0;
    logic last_m = 1'b1, id_m = 1'b0;
    logic [15:0] p_m = 16'd0;

    always #5 clk = ~clk;

    mul_arb_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .done_id(done_id), .p(p)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int runs_of(input logic [7:0] bv);
        int n;
`ifdef MUL_SKIP_ZERO_EN
        n = 1;
        for (int i = 0; i < 8; i++) if (bv[i]) n = i + 1;
`else
        n = 8;
`endif
        return n;
    endfunction

    function automatic logic [7:0] rnd8();
        int s;
        s = $urandom_range(0, 5);
        return s == 0 ? 8'h00 : s == 1 ? 8'hFF : 8'($urandom);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, {14'd0, gnt0, gnt1}, 16'd0);
        chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_done"}, {15'd0, done}, 16'd0);
        chk({tag, "_id"}, {15'd0, done_id}, 16'd0);
        chk({tag, "_p"}, p, 16'd0);
    endtask

    // Called in an IDLE cycle with requests already driven; walks one whole operation.
    task automatic transact(input bit late, input bit hold);
        logic w;
        logic [7:0] ea, eb;
        int n;
        w  = (req0 && req1) ? !last_m : req1;
        ea = w ? a1 : a0;
        eb = w ? b1 : b0;
        n  = runs_of(eb);
        @(negedge clk);
        chk("gnt0", {15'd0, gnt0}, {15'd0, !w});
        chk("gnt1", {15'd0, gnt1}, {15'd0, w});
        chk("busy_grant", {15'd0, busy}, 16'd1);
        chk("p_hold_grant", p, p_m);
        last_m = w;
        if (!hold) begin
            if (w) begin req1 = 1'b0; a1 = rnd8(); b1 = rnd8(); end
            else begin req0 = 1'b0; a0 = rnd8(); b0 = rnd8(); end
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (late && k == 2) begin
                if (w && !req0) begin req0 = 1'b1; a0 = rnd8(); b0 = rnd8(); end
                if (!w && !req1) begin req1 = 1'b1; a1 = rnd8(); b1 = rnd8(); end
            end
            chk("gnt_quiet", {14'd0, gnt0, gnt1}, 16'd0);
            chk("busy_run", {15'd0, busy}, 16'd1);
            chk("done", {15'd0, done}, (k == n) ? 16'd1 : 16'd0);
            if (k == n) begin
                p_m  = 16'(ea) * 16'(eb);
                id_m = w;
            end
            chk("p", p, p_m);
            chk("done_id", {15'd0, done_id}, {15'd0, id_m});
        end
        @(negedge clk);
        chk("idle_busy", {15'd0, busy}, 16'd0);
        chk("idle_done", {15'd0, done}, 16'd0);
        chk("idle_gnt", {14'd0, gnt0, gnt1}, 16'd0);
        chk("p_hold_idle", p, p_m);
    endtask

    initial begin
        int r;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_noreq_busy", {15'd0, busy}, 16'd0);
        chk("idle_noreq_gnt", {14'd0, gnt0, gnt1}, 16'd0);

        req0 = 1'b1; a0 = 8'h0C; b0 = 8'h0A;
        transact(1'b0, 1'b0);
        chk("single_p", p, 16'h0078);
        chk("single_id", {15'd0, done_id}, 16'd0);

        req1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF;
        transact(1'b0, 1'b0);
        chk("max_p", p, 16'hFE01);
        chk("max_id", {15'd0, done_id}, 16'd1);

        req0 = 1'b1; a0 = 8'h13; b0 = 8'hA7;
        req1 = 1'b1; a1 = 8'hC4; b1 = 8'h5B;
        transact(1'b0, 1'b1);
        transact(1'b0, 1'b1);
        transact(1'b0, 1'b0);
        transact(1'b0, 1'b0);

        req0 = 1'b1; a0 = 8'h37; b0 = 8'h00;
        transact(1'b0, 1'b0);
        chk("zero_p", p, 16'h0000);

        req0 = 1'b1; a0 = 8'h21; b0 = 8'hE3;
        transact(1'b1, 1'b0);
        transact(1'b0, 1'b0);

        req0 = 1'b1; a0 = rnd8(); b0 = 8'h80 | 8'($urandom);
        @(negedge clk);
        chk("rst_case_gnt0", {15'd0, gnt0}, 16'd1);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        rst_n = 1'b1;
        last_m = 1'b1; p_m = 16'd0; id_m = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("post_reset_done", {15'd0, done}, 16'd0);
            chk("post_reset_busy", {15'd0, busy}, 16'd0);
        end
        req1 = 1'b1; a1 = 8'h0F; b1 = 8'h11;
        transact(1'b0, 1'b0);
        chk("after_reset_p", p, 16'h00FF);

        for (int it = 0; it < 40; it++) begin
            if (!req0 && !req1) begin
                r = $urandom_range(1, 3);
                if (r[0]) begin req0 = 1'b1; a0 = rnd8(); b0 = rnd8(); end
                if (r[1]) begin req1 = 1'b1; a1 = rnd8(); b1 = rnd8(); end
            end
            transact(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
